vram_pingpong: RTL and testbench

Double-buffered, parametrised successor to the single-frame tile VRAM: two banks of X_SIZE×Y_SIZE cells, written sequentially from the serial receive path and read randomly by the VGA character/pixel fetch. The display always reads a complete front frame. A finished back frame is promoted only on the next `frame_sync` pulse, so no partial frame is ever shown and the display never tears. Sits between the SPI/UART receiver and the VGA renderer.

---
 rtl/vram_pingpong_if.sv | 32 +++
 rtl/vram_pingpong.sv | 113 +++++++++++
 tb/tb_vram_pingpong.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_pingpong_if.sv
`default_nettype none
// ============================================================================
// Module   : vram_pingpong_if
// Brief    : Receiver-write / VGA-read bus bundle for the ping-pong tile VRAM.
// Revision : 1.0 - initial release
// ============================================================================
interface vram_pingpong_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11
);
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  frame_sync;
  logic                  read_en;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  ready_flag;
  logic                  frame_pending;
  logic                  overrun;
  logic                  rd_bank;

  modport master (
    output rx_valid, data_in, frame_sync, read_en, read_addr,
    input  data_out, ready_flag, frame_pending, overrun, rd_bank
  );

  modport slave (
    input  rx_valid, data_in, frame_sync, read_en, read_addr,
    output data_out, ready_flag, frame_pending, overrun, rd_bank
  );
endinterface
`default_nettype wire

// File: rtl/vram_pingpong.sv
`default_nettype none
// ============================================================================
// Module   : vram_pingpong
// Brief    : Double-buffered tile VRAM; back frame is promoted on frame_sync
//            only once complete. Optional macro VRAM_RX_EDGE_EN makes writes
//            accept only on the rising edge of rx_valid.
// Revision : 1.0 - initial release
// ============================================================================
module vram_pingpong #(
  parameter int X_SIZE     = 40,
  parameter int Y_SIZE     = 30,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  vram_pingpong_if.slave bus
);
  localparam int                    c_DEPTH  = X_SIZE * Y_SIZE;
  localparam int                    c_PTR_W  = $clog2(c_DEPTH);
  localparam logic [c_PTR_W-1:0]    c_LAST   = c_PTR_W'(c_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] c_DEPTH_A = ADDR_WIDTH'(c_DEPTH);

  logic [DATA_WIDTH-1:0] r_bank0 [0:c_DEPTH-1];
  logic [DATA_WIDTH-1:0] r_bank1 [0:c_DEPTH-1];

  logic [c_PTR_W-1:0]    r_ptr;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_ready;
  logic                  r_pending;
  logic                  r_overrun;
  logic                  r_rd_bank;

  logic                  w_strobe;
  logic                  w_we;
  logic                  w_swap;
  logic [c_PTR_W-1:0]    w_rd_idx;
  logic                  w_rd_in_range;
  logic [DATA_WIDTH-1:0] w_rd_word;

`ifdef VRAM_RX_EDGE_EN
  logic r_rx_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_prev <= 1'b0;
    end else begin
      r_rx_prev <= bus.rx_valid;
    end
  end

  assign w_strobe = bus.rx_valid & ~r_rx_prev;
`else
  assign w_strobe = bus.rx_valid;
`endif

  // Pending and swap are mutually exclusive with a write, so the back bank
  // is never written in the same cycle it becomes the front.
  assign w_we          = w_strobe & ~r_pending;
  assign w_swap        = bus.frame_sync & r_pending;
  assign w_rd_idx      = bus.read_addr[c_PTR_W-1:0];
  assign w_rd_in_range = (bus.read_addr < c_DEPTH_A);
  assign w_rd_word     = r_rd_bank ? r_bank1[w_rd_idx] : r_bank0[w_rd_idx];

  always_ff @(posedge clk) begin
    if (w_we) begin
      if (r_rd_bank) begin
        r_bank0[r_ptr] <= bus.data_in;
      end else begin
        r_bank1[r_ptr] <= bus.data_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_data_out <= '0;
      r_ready    <= 1'b0;
      r_pending  <= 1'b0;
      r_overrun  <= 1'b0;
      r_rd_bank  <= 1'b0;
    end else begin
      r_overrun <= w_strobe & r_pending;

      if (w_we) begin
        if (r_ptr == c_LAST) begin
          r_ptr     <= '0;
          r_pending <= 1'b1;
        end else begin
          r_ptr <= r_ptr + 1'b1;
        end
      end

      if (w_swap) begin
        r_rd_bank <= ~r_rd_bank;
        r_pending <= 1'b0;
        r_ready   <= 1'b1;
      end

      if (bus.read_en && r_ready) begin
        r_data_out <= w_rd_in_range ? w_rd_word : '0;
      end
    end
  end

  assign bus.data_out      = r_data_out;
  assign bus.ready_flag    = r_ready;
  assign bus.frame_pending = r_pending;
  assign bus.overrun       = r_overrun;
  assign bus.rd_bank       = r_rd_bank;
endmodule
`default_nettype wire

// File: tb/tb_vram_pingpong.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_pingpong
// Brief    : Directed + random bench for vram_pingpong with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_pingpong;
  localparam int XS = 4;
  localparam int YS = 2;
  localparam int DEPTH = XS * YS;
  localparam int DW = 8;
  localparam int AW = 4;
`ifdef VRAM_RX_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vram_pingpong_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  vram_pingpong #(.X_SIZE(XS), .Y_SIZE(YS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Frame-level model: two frames, a fill count for the back frame, and flags.
  int m_frame [2][DEPTH];
  int m_fill;
  int m_front;
  bit m_full, m_shown, m_drop, m_prev_rx;
  int m_dout;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fill = 0; m_front = 0; m_full = 0; m_shown = 0; m_drop = 0;
      m_prev_rx = 0; m_dout = 0;
    end else begin
      bit strobe;
      bit fill_done_before;
      strobe = bus.rx_valid && (!EDGE || !m_prev_rx);
      m_prev_rx = bus.rx_valid;
      fill_done_before = m_full;
      if (bus.read_en && m_shown)
        m_dout = (int'(bus.read_addr) < DEPTH) ? m_frame[m_front][bus.read_addr] : 0;
      m_drop = strobe && fill_done_before;
      if (strobe && !fill_done_before) begin
        m_frame[1 - m_front][m_fill] = int'(bus.data_in);
        m_fill = m_fill + 1;
        if (m_fill == DEPTH) begin
          m_fill = 0;
          m_full = 1;
        end
      end
      if (bus.frame_sync && fill_done_before) begin
        m_front = 1 - m_front;
        m_full = 0;
        m_shown = 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  bit cmp_on = 0;
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cyc_data_out", int'(bus.data_out), m_dout);
      chk("cyc_ready", int'(bus.ready_flag), int'(m_shown));
      chk("cyc_pending", int'(bus.frame_pending), int'(m_full));
      chk("cyc_overrun", int'(bus.overrun), int'(m_drop));
      chk("cyc_rd_bank", int'(bus.rd_bank), m_front);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int d);
    bus.rx_valid = 1'b1; bus.data_in = DW'(d);
    step();
    bus.rx_valid = 1'b0;
    step();
  endtask

  task automatic sync();
    bus.frame_sync = 1'b1;
    step();
    bus.frame_sync = 1'b0;
  endtask

  task automatic read_all(input string name, input int base);
    for (int a = 0; a < DEPTH; a++) begin
      bus.read_en = 1'b1; bus.read_addr = AW'(a);
      step();
      chk(name, int'(bus.data_out), base + a);
    end
    bus.read_en = 1'b0;
  endtask

  task automatic fill(input int base);
    for (int i = 0; i < DEPTH; i++) wr(base + i);
  endtask

  initial begin
    bus.rx_valid = 0; bus.data_in = '0; bus.frame_sync = 0;
    bus.read_en = 0; bus.read_addr = '0;
    repeat (3) step();
    rst_n = 1'b1;
    cmp_on = 1;

    // Reset then read before any frame was shown
    bus.read_en = 1; bus.read_addr = '0;
    step(); step();
    chk("reset_data_out", int'(bus.data_out), 0);
    chk("reset_ready", int'(bus.ready_flag), 0);
    chk("reset_rd_bank", int'(bus.rd_bank), 0);
    bus.read_en = 0;

    // Fill and swap
    for (int i = 0; i < DEPTH - 1; i++) wr(8'h10 + i);
    chk("pending_before_last", int'(bus.frame_pending), 0);
    wr(8'h17);
    chk("pending_after_last", int'(bus.frame_pending), 1);
    sync();
    chk("swap1_rd_bank", int'(bus.rd_bank), 1);
    chk("swap1_ready", int'(bus.ready_flag), 1);
    chk("swap1_pending", int'(bus.frame_pending), 0);
    read_all("frameA", 8'h10);

    // Tear-free: back fill does not disturb the front
    fill(8'h20);
    read_all("tear_old", 8'h10);
    sync();
    chk("swap2_rd_bank", int'(bus.rd_bank), 0);
    read_all("tear_new", 8'h20);

    // Overrun
    fill(8'h40);
    bus.rx_valid = 1; bus.data_in = 8'hFF;
    step();
    chk("overrun_pulse", int'(bus.overrun), 1);
    bus.rx_valid = 0;
    step();
    chk("overrun_clear", int'(bus.overrun), 0);
    sync();
    chk("swap3_rd_bank", int'(bus.rd_bank), 1);
    read_all("after_overrun", 8'h40);

    // Last write coincident with frame_sync
    for (int i = 0; i < DEPTH - 1; i++) wr(8'h50 + i);
    bus.rx_valid = 1; bus.data_in = 8'h57; bus.frame_sync = 1;
    step();
    bus.rx_valid = 0; bus.frame_sync = 0;
    chk("race_pending", int'(bus.frame_pending), 1);
    chk("race_no_swap", int'(bus.rd_bank), 1);
    step();
    sync();
    chk("race_swap", int'(bus.rd_bank), 0);
    read_all("race_frame", 8'h50);

    // Out-of-range reads
    bus.read_en = 1; bus.read_addr = AW'(8);
    step();
    chk("oor_8", int'(bus.data_out), 0);
    bus.read_addr = AW'(3);
    step();
    chk("oor_then_3", int'(bus.data_out), 8'h53);
    bus.read_addr = AW'(15);
    step();
    chk("oor_15", int'(bus.data_out), 0);
    bus.read_en = 0;

    // rx_valid held high five cycles
    bus.rx_valid = 1; bus.data_in = 8'h60;
    repeat (5) step();
    bus.rx_valid = 0;
    step();
    begin
      int remain;
      remain = EDGE ? DEPTH - 1 : DEPTH - 5;
      for (int i = 0; i < remain - 1; i++) wr(8'h61 + i);
      chk("hold_not_full", int'(bus.frame_pending), 0);
      wr(8'h6F);
      chk("hold_full", int'(bus.frame_pending), 1);
    end
    sync();
    bus.read_en = 1; bus.read_addr = AW'(EDGE ? 1 : 4);
    step();
    chk("hold_cell", int'(bus.data_out), EDGE ? 8'h61 : 8'h60);
    bus.read_en = 0;

    // Async reset mid-frame
    for (int i = 0; i < 3; i++) wr(8'h70 + i);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_data_out", int'(bus.data_out), 0);
    chk("arst_ready", int'(bus.ready_flag), 0);
    chk("arst_rd_bank", int'(bus.rd_bank), 0);
    chk("arst_pending", int'(bus.frame_pending), 0);
    #2 rst_n = 1'b1;
    step();
    fill(8'h30);
    sync();
    chk("arst_swap_bank", int'(bus.rd_bank), 1);
    read_all("arst_frame", 8'h30);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bus.rx_valid   = ($urandom_range(0, 3) != 0);
      bus.data_in    = DW'($urandom);
      bus.frame_sync = ($urandom_range(0, 15) == 0);
      bus.read_en    = ($urandom_range(0, 1) == 1);
      bus.read_addr  = AW'($urandom_range(0, 15));
      step();
    end
    bus.rx_valid = 0; bus.frame_sync = 0; bus.read_en = 0;
    step();
    cmp_on = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
